// File: rtl/win_banner_bitmap.sv
`default_nettype none
// ============================================================================
//  Module      : win_banner_bitmap
//  Description : Animated 1-bit banner bitmap (reveal wipe, optional blink,
//                done flag). Optional blink stage: WIN_BANNER_BLINK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module win_banner_bitmap #(
   parameter int OBJECT_WIDTH_X  = 35,
   parameter int OBJECT_HEIGHT_Y = 6,
   parameter int SCALE_SHIFT     = 1,
   parameter logic [OBJECT_WIDTH_X*OBJECT_HEIGHT_Y-1:0] BITMAP = '1,
   parameter logic [7:0] FG_COLOR             = 8'hFF,
   parameter logic [7:0] TRANSPARENT_ENCODING = 8'h00,
   parameter int REVEAL_STEP  = 5,
   parameter int BLINK_FRAMES = 8,
   parameter int BLINK_COUNT  = 3
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [10:0] offsetX,
   input  logic [10:0] offsetY,
   input  logic        InsideRectangle,
   input  logic        startOfFrame,
   input  logic        show,
   output logic        drawingRequest,
   output logic [7:0]  RGBout,
   output logic        done
);

   localparam int C_MASK_BITS = OBJECT_WIDTH_X * OBJECT_HEIGHT_Y;
   localparam int C_IDX_W     = (C_MASK_BITS > 1) ? $clog2(C_MASK_BITS) : 1;
   localparam int C_REV_W     = $clog2(OBJECT_WIDTH_X + REVEAL_STEP + 1);
   localparam logic [10:0] C_W11 = 11'(OBJECT_WIDTH_X);
   localparam logic [10:0] C_H11 = 11'(OBJECT_HEIGHT_Y);
   localparam logic [C_REV_W-1:0] C_REV_MAX  = C_REV_W'(OBJECT_WIDTH_X);
   localparam logic [C_REV_W-1:0] C_REV_STEP = C_REV_W'(REVEAL_STEP);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REVEAL = 2'd1,
      ST_BLINK  = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

`ifdef WIN_BANNER_BLINK_EN
   localparam int C_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int C_PH_W  = (BLINK_COUNT > 0) ? $clog2(2 * BLINK_COUNT + 1) : 1;
   localparam logic [C_FRM_W-1:0] C_FRM_LAST = C_FRM_W'(BLINK_FRAMES - 1);
   localparam logic [C_PH_W-1:0]  C_PH_LAST  = C_PH_W'(2 * BLINK_COUNT);
   localparam state_t C_AFTER_REVEAL = (BLINK_COUNT > 0) ? ST_BLINK : ST_HOLD;

   logic [C_FRM_W-1:0] frmcnt_q, frmcnt_d;
   logic [C_PH_W-1:0]  phase_q, phase_d;
   logic               visible_q, visible_d;
`else
   localparam state_t C_AFTER_REVEAL = ST_HOLD;
`endif

   state_t             state_q, state_d;
   logic [C_REV_W-1:0] revcol_q, revcol_d;
   logic [7:0]         rgb_q, rgb_d;
   logic               done_q;

   logic [10:0]        w_mx, w_my;
   logic               w_in_range;
   logic [C_IDX_W-1:0] w_idx;
   logic               w_candidate;
   logic               w_draw;
   logic [C_REV_W-1:0] w_rev_sum;

   // ---------------------------------------------------------------- pixel path
   assign w_mx       = offsetX >> SCALE_SHIFT;
   assign w_my       = offsetY >> SCALE_SHIFT;
   assign w_in_range = (w_mx < C_W11) && (w_my < C_H11);

   // Index stays at 0 when out of range so the mask is never read past its end.
   always_comb begin
      w_idx = '0;
      if (w_in_range) begin
         w_idx = C_IDX_W'(C_H11 - 11'd1 - w_my) * C_IDX_W'(OBJECT_WIDTH_X)
               + C_IDX_W'(C_W11 - 11'd1 - w_mx);
      end
   end

   assign w_candidate = InsideRectangle && w_in_range && !BITMAP[w_idx];

   always_comb begin
      w_draw = 1'b0;
      case (state_q)
         ST_REVEAL: w_draw = w_candidate && (w_mx < 11'(revcol_q));
`ifdef WIN_BANNER_BLINK_EN
         ST_BLINK:  w_draw = w_candidate && visible_q;
`endif
         ST_HOLD:   w_draw = w_candidate;
         default:   w_draw = 1'b0;
      endcase
      rgb_d = w_draw ? FG_COLOR : TRANSPARENT_ENCODING;
   end

   // ---------------------------------------------------------- animation FSM
   assign w_rev_sum = revcol_q + C_REV_STEP;

   always_comb begin
      state_d  = state_q;
      revcol_d = revcol_q;
`ifdef WIN_BANNER_BLINK_EN
      frmcnt_d  = frmcnt_q;
      phase_d   = phase_q;
      visible_d = visible_q;
`endif
      if (!show) begin
         state_d  = ST_IDLE;
         revcol_d = '0;
`ifdef WIN_BANNER_BLINK_EN
         frmcnt_d  = '0;
         phase_d   = '0;
         visible_d = 1'b0;
`endif
      end else begin
         case (state_q)
            // A frame pulse coinciding with the start is deliberately dropped.
            ST_IDLE: begin
               state_d  = ST_REVEAL;
               revcol_d = '0;
            end
            ST_REVEAL: begin
               if (startOfFrame) begin
                  if (w_rev_sum >= C_REV_MAX) begin
                     revcol_d = C_REV_MAX;
                     state_d  = C_AFTER_REVEAL;
                  end else begin
                     revcol_d = w_rev_sum;
                  end
               end
            end
`ifdef WIN_BANNER_BLINK_EN
            ST_BLINK: begin
               if (startOfFrame) begin
                  if (frmcnt_q == C_FRM_LAST) begin
                     frmcnt_d  = '0;
                     visible_d = !visible_q;
                     phase_d   = phase_q + C_PH_W'(1);
                     if (phase_d == C_PH_LAST) begin
                        state_d = ST_HOLD;
                     end
                  end else begin
                     frmcnt_d = frmcnt_q + C_FRM_W'(1);
                  end
               end
            end
`endif
            ST_HOLD: state_d = ST_HOLD;
            default: state_d = ST_HOLD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= ST_IDLE;
         revcol_q <= '0;
         rgb_q    <= TRANSPARENT_ENCODING;
         done_q   <= 1'b0;
`ifdef WIN_BANNER_BLINK_EN
         frmcnt_q  <= '0;
         phase_q   <= '0;
         visible_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         revcol_q <= revcol_d;
         rgb_q    <= rgb_d;
         done_q   <= (state_d == ST_HOLD);
`ifdef WIN_BANNER_BLINK_EN
         frmcnt_q  <= frmcnt_d;
         phase_q   <= phase_d;
         visible_q <= visible_d;
`endif
      end
   end

   assign RGBout         = rgb_q;
   assign drawingRequest = (rgb_q != TRANSPARENT_ENCODING);
   assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_win_banner_bitmap.sv
`default_nettype none
// ============================================================================
//  Module      : tb_win_banner_bitmap
//  Description : Directed self-checking bench for win_banner_bitmap; adapts
//                to builds with or without WIN_BANNER_BLINK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_win_banner_bitmap;

   // Row 0 blank, row 1 cols 0..4 lit, row 2 fully lit, rows 3-4 blank,
   // row 5 only col 34 lit (0 = foreground).
   localparam logic [209:0] C_BMP = {
      35'h7_FFFF_FFFF,
      {5'b00000, 30'h3FFF_FFFF},
      35'h0_0000_0000,
      35'h7_FFFF_FFFF,
      35'h7_FFFF_FFFF,
      {34'h3_FFFF_FFFF, 1'b0}
   };

`ifdef WIN_BANNER_BLINK_EN
   localparam bit C_BLINK_ON = 1'b1;
`else
   localparam bit C_BLINK_ON = 1'b0;
`endif
   localparam int C_NPRE = C_BLINK_ON ? 31 : 3;

   logic        clk = 1'b0;
   logic        resetN;
   logic [10:0] ox, oy;
   logic        ins, sof, show;
   logic        dr1, dr2, done1, done2;
   logic [7:0]  rgb1, rgb2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   win_banner_bitmap #(.BITMAP(C_BMP)) u_dut (
      .clk(clk), .resetN(resetN), .offsetX(ox), .offsetY(oy),
      .InsideRectangle(ins), .startOfFrame(sof), .show(show),
      .drawingRequest(dr1), .RGBout(rgb1), .done(done1)
   );

   win_banner_bitmap #(.BITMAP(C_BMP), .SCALE_SHIFT(2)) u_dut_s2 (
      .clk(clk), .resetN(resetN), .offsetX(ox), .offsetY(oy),
      .InsideRectangle(ins), .startOfFrame(sof), .show(show),
      .drawingRequest(dr2), .RGBout(rgb2), .done(done2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      sof = 1'b1;
      tick();
      sof = 1'b0;
      tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetN = 1'b0; show = 1'b1; sof = 1'b0; ins = 1'b1;
      ox = 11'd0; oy = 11'd4;
      tick();
      tick();
      check("rst_rgb",  rgb1, 8'h00);
      check("rst_dr",   dr1, 1'b0);
      check("rst_done", done1, 1'b0);
      resetN = 1'b1;
      tick();
      check("idle_rgb", rgb1, 8'h00);
      tick();
      check("rev0_hidden", rgb1, 8'h00);

      // first frame: revCol = 5 -> screen x 0..9 visible on a lit row
      frame();
      for (int x = 0; x < 70; x++) begin
         ox = 11'(x);
         tick();
         check("scan_rgb", rgb1, (x < 10) ? 8'hFF : 8'h00);
         check("scan_dr",  dr1,  (x < 10) ? 1'b1 : 1'b0);
      end

      frame();
      frame();
      ox = 11'd29; tick(); check("rev15_in",  rgb1, 8'hFF);
      ox = 11'd30; tick(); check("rev15_out", rgb1, 8'h00);
      ins = 1'b0; ox = 11'd0; tick(); check("outside_rect", rgb1, 8'h00);
      ins = 1'b1;

      for (int f = 4; f <= 7; f++) frame();
      check("done_after_reveal", done1, C_BLINK_ON ? 1'b0 : 1'b1);
      ox = 11'd68; tick(); check("last_col", rgb1, C_BLINK_ON ? 8'h00 : 8'hFF);
      ox = 11'd70; tick(); check("beyond_mask", rgb1, 8'h00);

`ifdef WIN_BANNER_BLINK_EN
      for (int f = 1; f <= 48; f++) begin
         frame();
         ox = 11'd0;
         tick();
         check("blink_rgb", rgb1, ((f >= 48) || (((f / 8) % 2) == 1)) ? 8'hFF : 8'h00);
         check("blink_done", done1, (f >= 48) ? 1'b1 : 1'b0);
      end
`endif

      // steady HOLD
      check("hold_done", done1, 1'b1);
      oy = 11'd2; ox = 11'd8;  tick(); check("row1_col4", rgb1, 8'hFF);
      ox = 11'd10;             tick(); check("row1_col5", rgb1, 8'h00);
      oy = 11'd23; ox = 11'd136; tick();
      check("s2_row5_col34", rgb2, 8'hFF);
      check("s1_row11_oob",  rgb1, 8'h00);
      ox = 11'd132; tick(); check("s2_row5_col33", rgb2, 8'h00);
      oy = 11'd24;  ox = 11'd136; tick();
      check("s2_row6_oob", rgb2, 8'h00);
      check("s2_dr_oob",   dr2, 1'b0);

      // clear from HOLD
      oy = 11'd4; ox = 11'd0;
      show = 1'b0; tick();
      check("clear_done", done1, 1'b0);
      tick();
      check("clear_rgb", rgb1, 8'h00);
      check("clear_dr",  dr1, 1'b0);

      // restart, then drop show mid-animation (blink phase 3 when enabled)
      show = 1'b1; tick();
      for (int f = 0; f < C_NPRE; f++) frame();
      check("mid_done", done1, 1'b0);
      show = 1'b0; tick();
      show = 1'b1; sof = 1'b1; tick();
      check("restart_idle_rgb", rgb1, 8'h00);
      sof = 1'b0; ox = 11'd0; tick();
      check("restart_sof_ignored", rgb1, 8'h00);
      frame();
      ox = 11'd8;  tick(); check("restart_rev5_in",  rgb1, 8'hFF);
      ox = 11'd10; tick(); check("restart_rev5_out", rgb1, 8'h00);
      check("restart_done", done1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/win_banner_bitmap.md
# win_banner_bitmap

Parametrised, animated 1-bit banner bitmap for end-of-game text such as "YOU WIN" and "GAME OVER". It sits in the BMP drawing layer between a rectangle/offset generator and the objects mux. It maps screen offsets through an integer power-of-two scale onto a packed mask and emits a single foreground colour. It adds a frame-driven reveal wipe, an optional blink phase and a done flag.

## Interface
- OBJECT_WIDTH_X, default 35: mask width in mask pixels.
- OBJECT_HEIGHT_Y, default 6: mask height in mask pixels.
- SCALE_SHIFT, default 1: screen pixels per mask pixel = 2^SCALE_SHIFT on each axis.
- BITMAP, default all ones: packed mask of W*H bits. Row r occupies [(H-r)*W-1 : (H-1-r)*W]. Column c is bit (H-r)*W-1-c, so the literal reads left to right. Bit value 0 means foreground.
- FG_COLOR, default 8'hFF: RGB332 colour of foreground pixels.
- TRANSPARENT_ENCODING, default 8'h00: value meaning "do not draw".
- REVEAL_STEP, default 5: mask columns revealed per frame.
- BLINK_FRAMES, default 8: frames per blink half-period.
- BLINK_COUNT, default 3: number of on/off blink pairs.
- Ports:
  - clk, in, 1: system clock.
  - resetN, in, 1: asynchronous active-low reset.
  - offsetX, in, 11: X offset from the rectangle top-left.
  - offsetY, in, 11: Y offset from the rectangle top-left.
  - InsideRectangle, in, 1: pixel lies within the banner bracket.
  - startOfFrame, in, 1: one-cycle pulse per video frame.
  - show, in, 1: level input; 1 runs and keeps the banner, 0 clears it.
  - drawingRequest, out, 1: pixel should be displayed.
  - RGBout, out, 8: pixel colour.
  - done, out, 1: animation finished and banner is steady.

## Operation
- Mask coordinates: mx = offsetX >> SCALE_SHIFT, my = offsetY >> SCALE_SHIFT.
  - The pixel is a candidate only if InsideRectangle is 1, mx < W, my < H, and the mask bit is 0.
  - Out-of-range mx or my is transparent. The block never reads outside the mask.
- The state machine has four states: IDLE, REVEAL, BLINK and HOLD.
  - IDLE: nothing is drawn. When show = 1, clear revCol to 0 and go to REVEAL.
  - REVEAL: a candidate is drawn only if mx < revCol.
    - On each startOfFrame, revCol = min(revCol + REVEAL_STEP, W).
    - When revCol reaches W, go to BLINK, or to HOLD when blink is compiled out.
    - revCol saturates at W and never wraps.
  - BLINK: frmCnt counts startOfFrame pulses from 0 to BLINK_FRAMES-1.
    - On wrap, toggle visible, which starts at 0, and increment phase.
    - Candidates are drawn only while visible = 1.
    - After 2*BLINK_COUNT phases, go to HOLD.
  - HOLD: all candidates are drawn. done = 1.
- show = 0 in any state forces IDLE on the next clock edge. It also clears revCol, frmCnt, phase and visible.
- show toggling mid-animation restarts the animation from REVEAL with revCol = 0.

## Timing
- Reset values:
  - RGBout = TRANSPARENT_ENCODING.
  - drawingRequest = 0.
  - done = 0.
  - State = IDLE; all counters = 0; visible = 0.
- RGBout is registered: one-cycle latency from offsetX/offsetY/InsideRectangle to RGBout.
- drawingRequest = (RGBout != TRANSPARENT_ENCODING). It is combinational from RGBout and adds no extra latency.
- done is registered and asserts in the first cycle the state is HOLD.
- State transitions take effect on the clock edge after the triggering condition. The pixel path uses the pre-edge state.
- startOfFrame in the same cycle as the IDLE→REVEAL transition is ignored: revCol stays 0 for that edge.
- Simultaneous show = 0 and startOfFrame: IDLE wins and the counters clear.
- REVEAL frame count = ceil(W / REVEAL_STEP). The default is 7.
- BLINK frame count = 2 * BLINK_COUNT * BLINK_FRAMES. The default is 48.

## Configuration
- WIN_BANNER_BLINK_EN
  - Defined: the BLINK state and its counters are present. REVEAL goes to BLINK.
  - Undefined: BLINK, frmCnt and phase are not synthesised. REVEAL goes directly to HOLD, and done asserts 48 frames earlier with defaults.

## Test plan
- Reset mid-frame with show = 1, then release: RGBout = 8'h00, drawingRequest = 0, done = 0; no pixel drawn before a show rising edge is seen from IDLE.
- Defaults, show = 1, one startOfFrame, then scan offsetX 0..69 at a row whose mask bits are all 0: RGBout = 8'hFF exactly for offsetX 0..9, transparent for 10..69, each one clock after input.
- Seven startOfFrame pulses: revCol = 35 (saturated, not 35+), state is BLINK. offsetX = 70, beyond the mask with InsideRectangle = 1, stays transparent.
- With WIN_BANNER_BLINK_EN: 8 frames dark, 8 frames lit, repeated 3 times, then done = 1 after frame 55 and steady drawing. Without the macro: done = 1 immediately after frame 7.
- show = 0 during BLINK phase 3, then show = 1: the next cycle is IDLE with output transparent, then REVEAL restarts with revCol = 0 and done stays 0.
- SCALE_SHIFT = 2, H = 6: offsetY = 23 draws mask row 5, while offsetY = 24 is out of range and transparent even with InsideRectangle = 1.
